// File: rtl/world_clock_multi.sv
// Multi-zone world clock: free-running UTC base time, signed per-zone minute offsets,
// push-button adjust, auto-scroll and a registered display of the selected zone.
module world_clock_multi #(
  parameter int NUM_ZONES   = 4,
  parameter int TICK_DIV    = 12000000,
  parameter int SCROLL_SECS = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         zone_next,
  input  logic                         hour_inc,
  input  logic                         min_inc,
  input  logic                         scroll_en,
  output logic [$clog2(NUM_ZONES)-1:0] disp_zone,
  output logic [4:0]                   disp_hours,
  output logic [5:0]                   disp_minutes,
  output logic [5:0]                   disp_seconds,
  output logic [1:0]                   disp_day,
  output logic                         tick_1hz,
  output logic                         hour_tick,
  output logic                         day_tick
);

  localparam int ZW = $clog2(NUM_ZONES);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = $clog2(SCROLL_SECS + 1);
  localparam logic [PW-1:0] PRESC_MAX  = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCROLL_MAX = SW'(SCROLL_SECS - 1);
  localparam logic [ZW-1:0] ZONE_MAX   = ZW'(NUM_ZONES - 1);

  function automatic logic [10:0] wrap_mod(input logic [11:0] m);
    if (m >= 12'd1440) return 11'(m - 12'd1440);
    else return 11'(m);
  endfunction

  function automatic logic signed [11:0] wrap_off(input logic signed [11:0] o);
    if (o > 12'sd840) return o - 12'sd1560;
    else return o;
  endfunction

  logic [PW-1:0]      presc_q, presc_d;
  logic [5:0]         sec_q, sec_d;
  logic [10:0]        mod_q, mod_d;
  logic signed [11:0] off_q [NUM_ZONES];
  logic signed [11:0] off_d [NUM_ZONES];
  logic [ZW-1:0]      sel_q, sel_d;
  logic [SW-1:0]      scr_q, scr_d;
  logic [2:0]         btn_prev_q, btn_prev_d;
  logic               tick_1hz_q, tick_1hz_d;
  logic               hour_tick_q, hour_tick_d;
  logic               day_tick_q, day_tick_d;
  logic [ZW-1:0]      disp_zone_q, disp_zone_d;
  logic [4:0]         disp_hours_q, disp_hours_d;
  logic [5:0]         disp_minutes_q, disp_minutes_d;
  logic [5:0]         disp_seconds_q, disp_seconds_d;
  logic [1:0]         disp_day_q, disp_day_d;

  logic               tick, zn_act, hi_act, mi_act, base_adj, scroll_adv;
  logic [11:0]        mod_sum;
  logic signed [11:0] off_sel, off_delta;
  logic signed [12:0] t_raw, t_adj;
  logic [10:0]        t_min;

  // Next-state: prescaler, base time, offsets, zone select
  always_comb begin
    btn_prev_d = {zone_next, hour_inc, min_inc};
    zn_act     = zone_next & ~btn_prev_q[2];
    hi_act     = hour_inc  & ~btn_prev_q[1];
    mi_act     = min_inc   & ~btn_prev_q[0];
    tick       = (presc_q == PRESC_MAX);
    presc_d    = tick ? '0 : presc_q + PW'(1);
    tick_1hz_d = tick;
    base_adj   = (sel_q == '0) && (hi_act || mi_act);

    sec_d       = sec_q;
    mod_d       = mod_q;
    hour_tick_d = 1'b0;
    day_tick_d  = 1'b0;
    mod_sum     = {1'b0, mod_q} + (hi_act ? 12'd60 : 12'd0) + (mi_act ? 12'd1 : 12'd0);
    // A manual base adjust swallows the coincident tick's increment.
    if (base_adj) begin
      mod_d = wrap_mod(mod_sum);
      if (mi_act) sec_d = '0;
    end else if (tick) begin
      if (sec_q == 6'd59) begin
        sec_d       = '0;
        mod_d       = wrap_mod({1'b0, mod_q} + 12'd1);
        hour_tick_d = ((mod_q % 11'd60) == 11'd59);
        day_tick_d  = (mod_q == 11'd1439);
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end

    off_d     = off_q;
    off_sel   = off_q[sel_q];
    off_delta = (hi_act ? 12'sd60 : 12'sd0) + (mi_act ? 12'sd15 : 12'sd0);
    if ((sel_q != '0) && (hi_act || mi_act)) off_d[sel_q] = wrap_off(off_sel + off_delta);
    off_d[0] = '0;

    scr_d      = scr_q;
    scroll_adv = 1'b0;
    if (!scroll_en) begin
      scr_d = '0;
    end else if (tick) begin
      if (scr_q == SCROLL_MAX) begin
        scr_d      = '0;
        scroll_adv = 1'b1;
      end else begin
        scr_d = scr_q + SW'(1);
      end
    end

    sel_d = sel_q;
    if (zn_act || scroll_adv) sel_d = (sel_q == ZONE_MAX) ? '0 : sel_q + ZW'(1);
  end

  // Display: selected zone time folded into one day, with day-relative flag
  always_comb begin
    t_raw      = $signed({2'b00, mod_q}) + $signed({off_sel[11], off_sel});
    t_adj      = t_raw;
    disp_day_d = 2'b00;
    if (t_raw < 13'sd0) begin
      t_adj      = t_raw + 13'sd1440;
      disp_day_d = 2'b11;
    end else if (t_raw >= 13'sd1440) begin
      t_adj      = t_raw - 13'sd1440;
      disp_day_d = 2'b01;
    end
    t_min          = 11'(t_adj);
    disp_hours_d   = 5'(t_min / 11'd60);
    disp_minutes_d = 6'(t_min % 11'd60);
    disp_seconds_d = sec_q;
    disp_zone_d    = sel_q;
  end

  always_ff @(posedge clk) begin
    btn_prev_q <= btn_prev_d;
    if (reset) begin
      presc_q        <= '0;
      sec_q          <= '0;
      mod_q          <= '0;
      sel_q          <= '0;
      scr_q          <= '0;
      tick_1hz_q     <= 1'b0;
      hour_tick_q    <= 1'b0;
      day_tick_q     <= 1'b0;
      disp_zone_q    <= '0;
      disp_hours_q   <= '0;
      disp_minutes_q <= '0;
      disp_seconds_q <= '0;
      disp_day_q     <= '0;
      for (int k = 0; k < NUM_ZONES; k++) off_q[k] <= '0;
    end else begin
      presc_q        <= presc_d;
      sec_q          <= sec_d;
      mod_q          <= mod_d;
      sel_q          <= sel_d;
      scr_q          <= scr_d;
      tick_1hz_q     <= tick_1hz_d;
      hour_tick_q    <= hour_tick_d;
      day_tick_q     <= day_tick_d;
      disp_zone_q    <= disp_zone_d;
      disp_hours_q   <= disp_hours_d;
      disp_minutes_q <= disp_minutes_d;
      disp_seconds_q <= disp_seconds_d;
      disp_day_q     <= disp_day_d;
      for (int k = 0; k < NUM_ZONES; k++) off_q[k] <= off_d[k];
    end
  end

  assign disp_zone    = disp_zone_q;
  assign disp_hours   = disp_hours_q;
  assign disp_minutes = disp_minutes_q;
  assign disp_seconds = disp_seconds_q;
  assign disp_day     = disp_day_q;
  assign tick_1hz     = tick_1hz_q;
  assign hour_tick    = hour_tick_q;
  assign day_tick     = day_tick_q;

endmodule

// File: tb/tb_world_clock_multi.sv
// Directed bench for world_clock_multi with TICK_DIV=4, NUM_ZONES=4, SCROLL_SECS=2.
module tb_world_clock_multi;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       zone_next = 1'b0, hour_inc = 1'b0, min_inc = 1'b0, scroll_en = 1'b0;
  logic [1:0] disp_zone;
  logic [4:0] disp_hours;
  logic [5:0] disp_minutes, disp_seconds;
  logic [1:0] disp_day;
  logic       tick_1hz, hour_tick, day_tick;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ntk, first, last, badgap, nh, nd, nt, tcount, changes;
  logic [1:0] last_zone;

  world_clock_multi #(.NUM_ZONES(4), .TICK_DIV(4), .SCROLL_SECS(2)) dut (
    .clk(clk), .reset(reset), .zone_next(zone_next), .hour_inc(hour_inc),
    .min_inc(min_inc), .scroll_en(scroll_en), .disp_zone(disp_zone),
    .disp_hours(disp_hours), .disp_minutes(disp_minutes), .disp_seconds(disp_seconds),
    .disp_day(disp_day), .tick_1hz(tick_1hz), .hour_tick(hour_tick), .day_tick(day_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  // 0 = zone_next, 1 = hour_inc, 2 = min_inc, 3 = hour_inc+min_inc together
  task automatic press(input int which);
    zone_next = (which == 0);
    hour_inc  = (which == 1) || (which == 3);
    min_inc   = (which == 2) || (which == 3);
    step(1);
    zone_next = 1'b0;
    hour_inc  = 1'b0;
    min_inc   = 1'b0;
    step(1);
  endtask

  task automatic wait_ticks(input int target);
    int n;
    n = 0;
    for (int i = 0; i < 400 && n < target; i++) begin
      step(1);
      if (tick_1hz) n++;
    end
    chk("tick_wait", n, target);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_zone"}, disp_zone, 0);
    chk({tag, "_hours"}, disp_hours, 0);
    chk({tag, "_minutes"}, disp_minutes, 0);
    chk({tag, "_seconds"}, disp_seconds, 0);
    chk({tag, "_day"}, disp_day, 0);
    chk({tag, "_tick"}, tick_1hz, 0);
    chk({tag, "_hour_tick"}, hour_tick, 0);
    chk({tag, "_day_tick"}, day_tick, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Prescaler and base counting
    do_reset();
    chk_zero("rst");
    ntk = 0; first = -1; last = 0; badgap = 0;
    for (int i = 1; i <= 240; i++) begin
      step(1);
      if (tick_1hz) begin
        if (first < 0) first = i;
        else if (i - last != 4) badgap++;
        last = i;
        ntk++;
      end
    end
    chk("tick_count", ntk, 60);
    chk("tick_first", first, 4);
    chk("tick_gap", badgap, 0);
    step(1);
    chk("run_minutes", disp_minutes, 1);
    chk("run_seconds", disp_seconds, 0);
    chk("run_hours", disp_hours, 0);

    // Base set to 23:59:59, then day wrap
    do_reset();
    repeat (23) press(1);
    repeat (58) press(2);
    min_inc = 1'b1;
    step(1);
    min_inc = 1'b0;
    wait_ticks(59);
    step(1);
    chk("eod_hours", disp_hours, 23);
    chk("eod_minutes", disp_minutes, 59);
    chk("eod_seconds", disp_seconds, 59);
    nh = 0; nd = 0; nt = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      nh += int'(hour_tick);
      nd += int'(day_tick);
      nt += int'(tick_1hz);
    end
    chk("wrap_tick_cnt", nt, 1);
    chk("wrap_hour_tick", nh, 1);
    chk("wrap_day_tick", nd, 1);
    chk("wrap_hours", disp_hours, 0);
    chk("wrap_minutes", disp_minutes, 0);
    chk("wrap_seconds", disp_seconds, 0);
    chk("wrap_day", disp_day, 0);

    // Positive offset crossing into next day
    do_reset();
    repeat (20) press(1);
    press(0);
    repeat (9) press(1);
    chk("z1_zone", disp_zone, 1);
    chk("z1_hours", disp_hours, 5);
    chk("z1_minutes", disp_minutes, 0);
    chk("z1_day", disp_day, 1);
    repeat (3) press(0);
    chk("z0_zone", disp_zone, 0);
    chk("z0_hours", disp_hours, 20);
    chk("z0_minutes", disp_minutes, 0);
    chk("z0_day", disp_day, 0);

    // Offset wrap to negative, previous day
    do_reset();
    repeat (5) press(1);
    repeat (2) press(0);
    repeat (15) press(1);
    chk("z2_zone", disp_zone, 2);
    chk("z2_hours", disp_hours, 18);
    chk("z2_minutes", disp_minutes, 0);
    chk("z2_day", disp_day, 3);
    press(2);
    chk("z2m_hours", disp_hours, 18);
    chk("z2m_minutes", disp_minutes, 15);
    press(3);
    chk("z2b_hours", disp_hours, 19);
    chk("z2b_minutes", disp_minutes, 30);
    chk("z2b_day", disp_day, 3);

    // Held button, then base adjust coincident with a tick
    do_reset();
    hour_inc = 1'b1;
    step(100);
    hour_inc = 1'b0;
    step(1);
    chk("hold_hours", disp_hours, 1);
    chk("hold_minutes", disp_minutes, 0);
    repeat (58) press(2);
    min_inc = 1'b1;
    step(1);
    min_inc = 1'b0;
    wait_ticks(59);
    while (cyc % 4 != 3) step(1);
    min_inc = 1'b1;
    step(1);
    chk("coinc_tick", tick_1hz, 1);
    chk("coinc_hour_tick", hour_tick, 0);
    min_inc = 1'b0;
    step(1);
    chk("coinc_hours", disp_hours, 2);
    chk("coinc_minutes", disp_minutes, 0);
    chk("coinc_seconds", disp_seconds, 0);

    // Auto-scroll
    scroll_en = 1'b1;
    do_reset();
    last_zone = 2'd0; tcount = 0; changes = 0;
    for (int i = 0; i < 60 && changes < 4; i++) begin
      step(1);
      if (tick_1hz) tcount++;
      if (disp_zone != last_zone) begin
        chk("scroll_zone", disp_zone, (int'(last_zone) + 1) % 4);
        chk("scroll_ticks", tcount, 2);
        last_zone = disp_zone;
        tcount = 0;
        changes++;
      end
    end
    chk("scroll_changes", changes, 4);
    while (cyc % 8 != 7) step(1);
    zone_next = 1'b1;
    step(1);
    zone_next = 1'b0;
    step(1);
    chk("scroll_coinc_zone", disp_zone, 1);
    step(8);
    chk("scroll_after_zone", disp_zone, 2);

    // Reset mid-scroll with a button held
    hour_inc = 1'b1;
    do_reset();
    chk_zero("rst_scroll");
    step(10);
    chk("held_rst_hours", disp_hours, 0);
    hour_inc  = 1'b0;
    scroll_en = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/world_clock_multi.md
# world_clock_multi

Parametrised multi-zone world-clock core: one free-running base time (zone 0, UTC) driven by an internal 1 Hz prescaler, plus NUM_ZONES-1 signed minute offsets. Offsets are adjusted by push-button pulses. One zone at a time is presented on registered hour/minute/second/day-rollover outputs, for the 2-digit display decoders and the calendar. It replaces the fixed pair of 24-hour clocks and their offset-change logic with N zones, 15-minute offset granularity, negative offsets, day-rollover indication and auto-scroll.

## Interface
- NUM_ZONES, 4, number of zones (≥2); zone 0 is the base, offset fixed 0
- TICK_DIV, 12000000, clk cycles per second
- SCROLL_SECS, 5, seconds per zone in auto-scroll
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- zone_next  in  1  level, debounced; rising edge selects next zone
- hour_inc  in  1  level, debounced; rising edge = hour adjust
- min_inc  in  1  level, debounced; rising edge = minute adjust
- scroll_en  in  1  level; 1 = auto-advance zone every SCROLL_SECS seconds
- disp_zone  out  $clog2(NUM_ZONES)  zone currently shown
- disp_hours  out  5  0..23
- disp_minutes  out  6  0..59
- disp_seconds  out  6  0..59 (same for all zones)
- disp_day  out  2  2'b00 same day, 2'b01 next day, 2'b11 previous day, relative to base
- tick_1hz  out  1  one-cycle pulse per second
- hour_tick  out  1  one-cycle pulse when base crosses an hour via tick
- day_tick  out  1  one-cycle pulse when base wraps 23:59:59→00:00:00 via tick

## Operation
- Prescaler 0..TICK_DIV-1. At count TICK_DIV-1 a tick occurs, tick_1hz is high for that cycle, and the prescaler returns to 0.
- Base state: sec 0..59 and mod 0..1439 (minute of day, 11 bits). A tick increments sec. When sec is at 59, sec becomes 0 and mod advances, with 1439 wrapping to 0.
- Offsets: offset[k] is 12-bit signed minutes, legal range -720..+840, reset value 0. offset[0] is constant 0.
- Button edges: each button has a prev register, and an action occurs when level=1 and prev=0. Holding a button produces exactly one action.
- Selected zone = 0, adjusting base:
  - hour_inc: mod = (mod+60) mod 1440.
  - min_inc: mod = (mod+1) mod 1440 and sec = 0.
- Selected zone k>0, adjusting offset[k]:
  - hour_inc adds +60, min_inc adds +15.
  - If the result exceeds 840, subtract 1560.
- Zone select:
  - zone_next edge: disp_zone+1, with NUM_ZONES-1 wrapping to 0.
  - Scroll: with scroll_en=1, a scroll counter counts ticks. After SCROLL_SECS ticks it advances the zone and clears.
  - Clearing scroll_en clears the scroll counter.
  - zone_next and a scroll advance on the same cycle advance the zone once, and the scroll counter clears.
- Zone time: t = mod + offset[sel], signed 13-bit.
  - t<0: t+=1440, day=11.
  - t≥1440: t-=1440, day=01.
  - Otherwise day=00.
  - hours = t/60, minutes = t%60.
- Priority on base: a manual base adjust and a tick on the same edge → the adjust applies and the tick's sec/mod increment is dropped. tick_1hz still pulses and the prescaler still wraps. hour_tick/day_tick do not fire.
- Offset adjust and tick on the same edge: both apply.
- hour_inc and min_inc on the same edge: both apply, as +61 to mod (+75 to an offset), with one wrap step.

## Timing
- Inputs are sampled on the clk rising edge. An action occurs at the edge where the rising edge is detected (edge N).
- disp_* are registered from the post-update state and show the result at edge N+1 (1-cycle latency).
- tick_1hz is registered, high the cycle after the prescaler reaches TICK_DIV-1. sec updates at the same edge that raises tick_1hz.
- hour_tick/day_tick are high during the same cycle as the tick_1hz that caused the crossing.
- Reset (any cycle, including mid-scroll or with a button held):
  - Cleared: prescaler, sec, mod, all offsets, disp_zone, scroll counter.
  - All outputs read 0 the cycle after reset.
  - prev registers load the current button levels, so a button held through reset causes no action.

## Test plan
(TICK_DIV=4, NUM_ZONES=4, SCROLL_SECS=2)
- Reset, then 240 cycles → 60 tick_1hz pulses spaced 4 cycles apart; disp_minutes=1, disp_seconds=0, disp_hours=0.
- Zone 0: 23 hour_inc edges and 59 min_inc edges, then 59 ticks (base 23:59:59); next tick → 00:00:00, with exactly one hour_tick and one day_tick pulse.
- Zone 1: 9 hour_inc edges (+540); base 20:00 → disp 05:00, disp_day=01. Zone 0 still shows 20:00, disp_day=00.
- Zone 2: 15 hour_inc edges → offset -660; base 05:00 → disp 18:00, disp_day=11. One more min_inc → 18:15.
- hour_inc held 100 cycles → single +1 h. Zone 0 min_inc coincident with a tick → sec=0, no hour_tick.
- scroll_en=1 → disp_zone 0→1→2→3→0, one step every 2 ticks. zone_next and a scroll advance on the same edge → +1 only. Reset mid-scroll → all outputs 0 the next cycle.
